// File: rtl/issue_scheduler_if.sv
// Issue handshake bundle between the scheduler and its three functional units.
// FU0/FU1 are the ALU pipes, FU2 is the memory pipe.
interface issue_scheduler_if #(
    parameter int unsigned IDX_W = 6
);
    logic             fu0_valid;
    logic [IDX_W-1:0] fu0_idx;
    logic             fu0_ready;
    logic             fu1_valid;
    logic [IDX_W-1:0] fu1_idx;
    logic             fu1_ready;
    logic             fu2_valid;
    logic [IDX_W-1:0] fu2_idx;
    logic             fu2_ready;

    modport master (
        output fu0_valid, fu0_idx, fu1_valid, fu1_idx, fu2_valid, fu2_idx,
        input  fu0_ready, fu1_ready, fu2_ready
    );

    modport slave (
        input  fu0_valid, fu0_idx, fu1_valid, fu1_idx, fu2_valid, fu2_idx,
        output fu0_ready, fu1_ready, fu2_ready
    );
endinterface

// File: rtl/issue_scheduler.sv
// Reservation-station issue controller: owns the physical-register ready table,
// wakes entries on writeback and issues round-robin to two ALU pipes and one memory pipe.
module issue_scheduler #(
    parameter int unsigned RS_ROW_COUNT = 64,
    parameter int unsigned RS_IDX_W     = 6,
    parameter int unsigned PREG_COUNT   = 64,
    parameter int unsigned PREG_W       = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [RS_ROW_COUNT-1:0]        rs_valid,
    input  logic [RS_ROW_COUNT-1:0]        rs_is_mem,
    input  logic [RS_ROW_COUNT-1:0]        rs_rdy1,
    input  logic [RS_ROW_COUNT-1:0]        rs_rdy2,
    input  logic [RS_ROW_COUNT*PREG_W-1:0] rs_src1_flat,
    input  logic [RS_ROW_COUNT*PREG_W-1:0] rs_src2_flat,
    input  logic [1:0]                     alloc_en,
    input  logic [2*PREG_W-1:0]            alloc_preg,
    input  logic [1:0]                     wb_en,
    input  logic [2*PREG_W-1:0]            wb_preg,
    output logic [PREG_COUNT-1:0]          ready_table,
    output logic [RS_ROW_COUNT-1:0]        issue_clear,
    issue_scheduler_if.master              fu
);
    localparam int unsigned FU_CNT = 3;

    logic [PREG_COUNT-1:0]           ready_table_q, ready_table_d;
    logic [FU_CNT-1:0]               fu_valid_q, fu_valid_d;
    logic [FU_CNT-1:0][RS_IDX_W-1:0] fu_idx_q, fu_idx_d;
    logic [RS_ROW_COUNT-1:0]         held_q, held_d;
    logic [RS_ROW_COUNT-1:0]         issue_clear_q, issue_clear_d;
    logic [RS_IDX_W-1:0]             alu_ptr_q, alu_ptr_d;
    logic [RS_IDX_W-1:0]             mem_ptr_q, mem_ptr_d;

    logic [PREG_COUNT-1:0]   fwd_c;
    logic [RS_ROW_COUNT-1:0] elig_c;
    logic [RS_ROW_COUNT-1:0] alu_rot_c, mem_rot_c;
    logic [FU_CNT-1:0]       fu_ready_c, fu_free_c, fu_accept_c;
    logic [RS_IDX_W:0]       alu_a_c, alu_b_c, mem_a_c;
    logic [RS_IDX_W-1:0]     alu_a_idx_c, alu_b_idx_c, mem_a_idx_c;

    // Rotate right so that bit 0 of the result is the entry at the scan pointer.
    function automatic logic [RS_ROW_COUNT-1:0] rotate(input logic [RS_ROW_COUNT-1:0] v,
                                                       input logic [RS_IDX_W-1:0]     sh);
        logic [2*RS_ROW_COUNT-1:0] dbl;
        dbl    = {v, v};
        rotate = dbl[sh +: RS_ROW_COUNT];
    endfunction

    // Returns {found, offset} of the lowest set bit.
    function automatic logic [RS_IDX_W:0] first_hit(input logic [RS_ROW_COUNT-1:0] v);
        first_hit = '0;
        for (int k = RS_ROW_COUNT - 1; k >= 0; k--) begin
            if (v[k]) first_hit = {1'b1, RS_IDX_W'(k)};
        end
    endfunction

    // Wakeup: ready table plus this cycle's writebacks decide operand readiness.
    always_comb begin
        fwd_c  = ready_table_q;
        elig_c = '0;
        for (int k = 0; k < 2; k++) begin
            if (wb_en[k]) fwd_c[wb_preg[k*PREG_W +: PREG_W]] = 1'b1;
        end
        // An entry whose clear pulse is in flight is still occupied in the RS this cycle.
        for (int i = 0; i < RS_ROW_COUNT; i++) begin
            elig_c[i] = rs_valid[i] & ~held_q[i] & ~issue_clear_q[i]
                      & (rs_rdy1[i] | fwd_c[rs_src1_flat[i*PREG_W +: PREG_W]])
                      & (rs_rdy2[i] | fwd_c[rs_src2_flat[i*PREG_W +: PREG_W]]);
        end
    end

    assign fu_ready_c  = {fu.fu2_ready, fu.fu1_ready, fu.fu0_ready};
    assign fu_accept_c = fu_valid_q & fu_ready_c;
    assign fu_free_c   = ~fu_valid_q | fu_ready_c;

    assign alu_rot_c   = rotate(elig_c & ~rs_is_mem, alu_ptr_q);
    assign mem_rot_c   = rotate(elig_c & rs_is_mem, mem_ptr_q);
    assign alu_a_c     = first_hit(alu_rot_c);
    assign alu_b_c     = first_hit(alu_rot_c & ~(RS_ROW_COUNT'(1) << alu_a_c[RS_IDX_W-1:0]));
    assign mem_a_c     = first_hit(mem_rot_c);
    assign alu_a_idx_c = alu_a_c[RS_IDX_W-1:0] + alu_ptr_q;
    assign alu_b_idx_c = alu_b_c[RS_IDX_W-1:0] + alu_ptr_q;
    assign mem_a_idx_c = mem_a_c[RS_IDX_W-1:0] + mem_ptr_q;

    always_comb begin
        ready_table_d = ready_table_q;
        fu_valid_d    = fu_valid_q;
        fu_idx_d      = fu_idx_q;
        held_d        = held_q;
        issue_clear_d = '0;
        alu_ptr_d     = alu_ptr_q;
        mem_ptr_d     = mem_ptr_q;

        // Allocation is applied after writeback so it wins on a shared tag.
        for (int k = 0; k < 2; k++) begin
            if (wb_en[k]) ready_table_d[wb_preg[k*PREG_W +: PREG_W]] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (alloc_en[k]) ready_table_d[alloc_preg[k*PREG_W +: PREG_W]] = 1'b0;
        end
        ready_table_d[0] = 1'b1;

        for (int n = 0; n < FU_CNT; n++) begin
            if (fu_accept_c[n]) begin
                issue_clear_d[fu_idx_q[n]] = 1'b1;
                held_d[fu_idx_q[n]]        = 1'b0;
                fu_valid_d[n]              = 1'b0;
            end
        end

        if (fu_free_c[0] && fu_free_c[1]) begin
            if (alu_a_c[RS_IDX_W]) begin
                fu_valid_d[0]       = 1'b1;
                fu_idx_d[0]         = alu_a_idx_c;
                held_d[alu_a_idx_c] = 1'b1;
                alu_ptr_d           = alu_a_idx_c + RS_IDX_W'(1);
            end
            if (alu_b_c[RS_IDX_W]) begin
                fu_valid_d[1]       = 1'b1;
                fu_idx_d[1]         = alu_b_idx_c;
                held_d[alu_b_idx_c] = 1'b1;
                alu_ptr_d           = alu_b_idx_c + RS_IDX_W'(1);
            end
        end else if (alu_a_c[RS_IDX_W] && (fu_free_c[0] || fu_free_c[1])) begin
            fu_valid_d[{1'b0, ~fu_free_c[0]}] = 1'b1;
            fu_idx_d[{1'b0, ~fu_free_c[0]}]   = alu_a_idx_c;
            held_d[alu_a_idx_c]               = 1'b1;
            alu_ptr_d                         = alu_a_idx_c + RS_IDX_W'(1);
        end

        if (fu_free_c[2] && mem_a_c[RS_IDX_W]) begin
            fu_valid_d[2]       = 1'b1;
            fu_idx_d[2]         = mem_a_idx_c;
            held_d[mem_a_idx_c] = 1'b1;
            mem_ptr_d           = mem_a_idx_c + RS_IDX_W'(1);
        end

        // Flush drops in-flight issues silently; the ready table keeps updating.
        if (flush) begin
            fu_valid_d    = '0;
            held_d        = '0;
            issue_clear_d = '0;
            alu_ptr_d     = alu_ptr_q;
            mem_ptr_d     = mem_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_table_q <= '1;
            fu_valid_q    <= '0;
            fu_idx_q      <= '0;
            held_q        <= '0;
            issue_clear_q <= '0;
            alu_ptr_q     <= '0;
            mem_ptr_q     <= '0;
        end else begin
            ready_table_q <= ready_table_d;
            fu_valid_q    <= fu_valid_d;
            fu_idx_q      <= fu_idx_d;
            held_q        <= held_d;
            issue_clear_q <= issue_clear_d;
            alu_ptr_q     <= alu_ptr_d;
            mem_ptr_q     <= mem_ptr_d;
        end
    end

    assign ready_table  = ready_table_q;
    assign issue_clear  = issue_clear_q;
    assign fu.fu0_valid = fu_valid_q[0];
    assign fu.fu0_idx   = fu_idx_q[0];
    assign fu.fu1_valid = fu_valid_q[1];
    assign fu.fu1_idx   = fu_idx_q[1];
    assign fu.fu2_valid = fu_valid_q[2];
    assign fu.fu2_idx   = fu_idx_q[2];
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic, each cycle
// checked against a queue-based reference model of the issue rules.
module tb_issue_scheduler;
    localparam int unsigned N  = 64;
    localparam int unsigned IW = 6;
    localparam int unsigned PW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      rs_valid, rs_is_mem, rs_rdy1, rs_rdy2;
    logic [N*PW-1:0]   rs_src1_flat, rs_src2_flat;
    logic [1:0]        alloc_en, wb_en;
    logic [2*PW-1:0]   alloc_preg, wb_preg;
    logic [63:0]       ready_table;
    logic [N-1:0]      issue_clear;

    issue_scheduler_if #(.IDX_W(IW)) fu_if ();

    issue_scheduler #(
        .RS_ROW_COUNT(N), .RS_IDX_W(IW), .PREG_COUNT(64), .PREG_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rs_valid(rs_valid), .rs_is_mem(rs_is_mem), .rs_rdy1(rs_rdy1), .rs_rdy2(rs_rdy2),
        .rs_src1_flat(rs_src1_flat), .rs_src2_flat(rs_src2_flat),
        .alloc_en(alloc_en), .alloc_preg(alloc_preg), .wb_en(wb_en), .wb_preg(wb_preg),
        .ready_table(ready_table), .issue_clear(issue_clear), .fu(fu_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ri;

    // Reference model state (m_*) and its next value (n_*).
    logic [63:0] m_rt, n_rt, m_clr, n_clr;
    logic [2:0]  m_fv, n_fv;
    int          m_fidx[3], n_fidx[3];
    int          m_aptr, n_aptr, m_mptr, n_mptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rt   = '1;
        m_clr  = '0;
        m_fv   = '0;
        m_fidx = '{0, 0, 0};
        m_aptr = 0;
        m_mptr = 0;
    endtask

    task automatic model_next();
        logic [63:0] fwd, blocked, elig;
        logic [2:0]  rdy, free;
        int          alu_hits[$];
        int          mem_hits[$];
        int          ja, jm;
        fwd = m_rt;
        for (int k = 0; k < 2; k++) if (wb_en[k]) fwd[wb_preg[k*PW +: PW]] = 1'b1;
        blocked = m_clr;
        for (int n = 0; n < 3; n++) if (m_fv[n]) blocked[m_fidx[n]] = 1'b1;
        for (int i = 0; i < N; i++)
            elig[i] = rs_valid[i] && !blocked[i]
                   && (rs_rdy1[i] || fwd[rs_src1_flat[i*PW +: PW]])
                   && (rs_rdy2[i] || fwd[rs_src2_flat[i*PW +: PW]]);
        for (int k = 0; k < N; k++) begin
            ja = (m_aptr + k) % N;
            jm = (m_mptr + k) % N;
            if (elig[ja] && !rs_is_mem[ja]) alu_hits.push_back(ja);
            if (elig[jm] && rs_is_mem[jm]) mem_hits.push_back(jm);
        end
        rdy    = {fu_if.fu2_ready, fu_if.fu1_ready, fu_if.fu0_ready};
        free   = ~m_fv | rdy;
        n_fv   = m_fv;
        n_fidx = m_fidx;
        n_clr  = '0;
        n_aptr = m_aptr;
        n_mptr = m_mptr;
        for (int n = 0; n < 3; n++) begin
            if (m_fv[n] && rdy[n]) begin
                n_clr[m_fidx[n]] = 1'b1;
                n_fv[n] = 1'b0;
            end
        end
        if (free[0] && free[1]) begin
            if (alu_hits.size() > 0) begin
                n_fv[0] = 1'b1; n_fidx[0] = alu_hits[0]; n_aptr = (alu_hits[0] + 1) % N;
            end
            if (alu_hits.size() > 1) begin
                n_fv[1] = 1'b1; n_fidx[1] = alu_hits[1]; n_aptr = (alu_hits[1] + 1) % N;
            end
        end else if (alu_hits.size() > 0) begin
            if (free[0]) begin
                n_fv[0] = 1'b1; n_fidx[0] = alu_hits[0]; n_aptr = (alu_hits[0] + 1) % N;
            end else if (free[1]) begin
                n_fv[1] = 1'b1; n_fidx[1] = alu_hits[0]; n_aptr = (alu_hits[0] + 1) % N;
            end
        end
        if (free[2] && mem_hits.size() > 0) begin
            n_fv[2] = 1'b1; n_fidx[2] = mem_hits[0]; n_mptr = (mem_hits[0] + 1) % N;
        end
        if (flush) begin
            n_fv   = '0;
            n_clr  = '0;
            n_aptr = m_aptr;
            n_mptr = m_mptr;
        end
        n_rt = m_rt;
        for (int k = 0; k < 2; k++) if (wb_en[k]) n_rt[wb_preg[k*PW +: PW]] = 1'b1;
        for (int k = 0; k < 2; k++)
            if (alloc_en[k] && alloc_preg[k*PW +: PW] != 6'd0) n_rt[alloc_preg[k*PW +: PW]] = 1'b0;
    endtask

    task automatic check_all();
        chk("ready_table", ready_table, m_rt);
        chk("issue_clear", issue_clear, m_clr);
        chk("fu_valid", 64'({fu_if.fu2_valid, fu_if.fu1_valid, fu_if.fu0_valid}), 64'(m_fv));
        if (m_fv[0]) chk("fu0_idx", 64'(fu_if.fu0_idx), 64'(m_fidx[0]));
        if (m_fv[1]) chk("fu1_idx", 64'(fu_if.fu1_idx), 64'(m_fidx[1]));
        if (m_fv[2]) chk("fu2_idx", 64'(fu_if.fu2_idx), 64'(m_fidx[2]));
    endtask

    // One clock: predict, let the DUT take the edge, free RS entries whose clear just ended, compare.
    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        rs_valid = rs_valid & ~m_clr;
        m_rt   = n_rt;   m_clr  = n_clr;
        m_fv   = n_fv;   m_fidx = n_fidx;
        m_aptr = n_aptr; m_mptr = n_mptr;
        check_all();
    endtask

    task automatic set_entry(input int i, input bit mem, input bit r1, input bit r2,
                             input int s1, input int s2);
        rs_valid[i]  = 1'b1;
        rs_is_mem[i] = mem;
        rs_rdy1[i]   = r1;
        rs_rdy2[i]   = r2;
        rs_src1_flat[i*PW +: PW] = PW'(s1);
        rs_src2_flat[i*PW +: PW] = PW'(s2);
    endtask

    task automatic set_ready(input bit r0, input bit r1, input bit r2);
        fu_if.fu0_ready = r0;
        fu_if.fu1_ready = r1;
        fu_if.fu2_ready = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        rs_valid = '0; rs_is_mem = '0; rs_rdy1 = '0; rs_rdy2 = '0;
        rs_src1_flat = '0; rs_src2_flat = '0;
        alloc_en = '0; alloc_preg = '0; wb_en = '0; wb_preg = '0;
        set_ready(1'b1, 1'b1, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready_table", ready_table, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset_valids", 64'({fu_if.fu2_valid, fu_if.fu1_valid, fu_if.fu0_valid}), 64'd0);
        chk("reset_issue_clear", issue_clear, 64'd0);
        rst_n = 1'b1;

        // Ready table: alloc, wakeup, alloc-over-wb, tag 0 pinned.
        alloc_en = 2'b01; alloc_preg = {6'd0, 6'd5};
        step();
        chk("rt5_after_alloc", 64'(ready_table[5]), 64'd0);
        alloc_en = 2'b00; wb_en = 2'b01; wb_preg = {6'd0, 6'd5};
        step();
        chk("rt5_after_wb", 64'(ready_table[5]), 64'd1);
        alloc_en = 2'b01; alloc_preg = {6'd0, 6'd9}; wb_en = 2'b10; wb_preg = {6'd9, 6'd0};
        step();
        chk("rt9_alloc_wins", 64'(ready_table[9]), 64'd0);
        alloc_en = 2'b11; alloc_preg = {6'd0, 6'd0}; wb_en = 2'b00;
        step();
        chk("rt0_pinned", 64'(ready_table[0]), 64'd1);
        alloc_en = 2'b00;

        // ALU round-robin from pointer 0 with entries 3, 7, 12.
        set_entry(3, 1'b0, 1'b1, 1'b1, 0, 0);
        set_entry(7, 1'b0, 1'b1, 1'b1, 0, 0);
        set_entry(12, 1'b0, 1'b1, 1'b1, 0, 0);
        step();
        chk("alu_c1_fu0", 64'(fu_if.fu0_idx), 64'd3);
        chk("alu_c1_fu1", 64'(fu_if.fu1_idx), 64'd7);
        step();
        chk("alu_c2_fu0", 64'(fu_if.fu0_idx), 64'd12);
        chk("alu_c2_fu1_valid", 64'(fu_if.fu1_valid), 64'd0);
        chk("alu_c2_clear", issue_clear, (64'd1 << 3) | (64'd1 << 7));
        set_entry(5, 1'b0, 1'b1, 1'b1, 0, 0);
        set_entry(14, 1'b0, 1'b1, 1'b1, 0, 0);
        step();
        chk("alu_c3_clear", issue_clear, 64'd1 << 12);
        step();
        chk("alu_ptr13_fu0", 64'(fu_if.fu0_idx), 64'd14);
        chk("alu_ptr13_fu1", 64'(fu_if.fu1_idx), 64'd5);
        repeat (2) step();

        // Memory entry woken by same-cycle writeback, then stalled.
        set_ready(1'b1, 1'b1, 1'b0);
        alloc_en = 2'b01; alloc_preg = {6'd0, 6'd20};
        step();
        alloc_en = 2'b00;
        set_entry(4, 1'b1, 1'b0, 1'b1, 20, 0);
        step();
        chk("mem_not_ready", 64'(fu_if.fu2_valid), 64'd0);
        wb_en = 2'b01; wb_preg = {6'd0, 6'd20};
        step();
        chk("mem_fwd_valid", 64'(fu_if.fu2_valid), 64'd1);
        chk("mem_fwd_idx", 64'(fu_if.fu2_idx), 64'd4);
        wb_en = 2'b00;
        repeat (3) begin
            step();
            chk("mem_stall_idx", 64'(fu_if.fu2_idx), 64'd4);
            chk("mem_stall_noclear", 64'(issue_clear[4]), 64'd0);
        end
        fu_if.fu2_ready = 1'b1;
        step();
        chk("mem_clear_pulse", 64'(issue_clear[4]), 64'd1);
        step();
        chk("mem_clear_once", 64'(issue_clear[4]), 64'd0);

        // Flush while FU0 is stalled on entry 2.
        set_ready(1'b0, 1'b0, 1'b1);
        set_entry(2, 1'b0, 1'b1, 1'b1, 0, 0);
        step();
        chk("flush_pre_idx", 64'(fu_if.fu0_idx), 64'd2);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid_drop", 64'(fu_if.fu0_valid), 64'd0);
        chk("flush_no_clear", issue_clear, 64'd0);
        step();
        chk("flush_reissue_valid", 64'(fu_if.fu0_valid), 64'd1);
        chk("flush_reissue_idx", 64'(fu_if.fu0_idx), 64'd2);
        fu_if.fu0_ready = 1'b1;
        step();
        chk("flush_late_clear", 64'(issue_clear[2]), 64'd1);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            repeat (2) begin
                ri = int'($urandom_range(0, N - 1));
                if (!rs_valid[ri])
                    set_entry(ri, ($urandom % 3) == 0, 1'($urandom % 2), 1'($urandom % 2),
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            alloc_en   = 2'($urandom);
            alloc_preg = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            wb_en      = 2'($urandom);
            wb_preg    = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            set_ready(($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 6);
            flush      = ($urandom % 25) == 0;
            step();
        end
        alloc_en = 2'b00; wb_en = 2'b00;

        // Asynchronous reset in the middle of a handshake.
        flush = 1'b1;
        step();
        flush = 1'b0;
        rs_valid = '0;
        step();
        set_ready(1'b0, 1'b0, 1'b0);
        set_entry(1, 1'b0, 1'b1, 1'b1, 0, 0);
        set_entry(2, 1'b0, 1'b1, 1'b1, 0, 0);
        step();
        chk("pre_reset_fu1_valid", 64'(fu_if.fu1_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valids", 64'({fu_if.fu2_valid, fu_if.fu1_valid, fu_if.fu0_valid}), 64'd0);
        chk("async_rst_idx", 64'({fu_if.fu2_idx, fu_if.fu1_idx, fu_if.fu0_idx}), 64'd0);
        chk("async_rst_clear", issue_clear, 64'd0);
        chk("async_rst_table", ready_table, 64'hFFFF_FFFF_FFFF_FFFF);
        model_reset();
        rs_valid = '0;
        #2;
        rst_n = 1'b1;
        step();
        chk("post_reset_no_clear", issue_clear, 64'd0);
        set_ready(1'b1, 1'b1, 1'b1);
        set_entry(6, 1'b0, 1'b1, 1'b1, 0, 0);
        step();
        chk("post_reset_issue", 64'(fu_if.fu0_idx), 64'd6);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
